// File: rtl/fifo_wr_feeder.sv
// fifo_wr_feeder: write-domain producer feeding an async FIFO write port.
// A valid/ready stream is taken into a 2-entry skid buffer and drained into the
// FIFO with wr_en_o/wdata_o. Writes never occur while full_i is high. FIFO write
// errors are latched sticky and halt the stream until cleared.
// Optional build macro: FIFO_WR_FEEDER_STALL_CNT_EN enables the full-stall
// cycle counter on stall_cnt_o (otherwise the port is tied to zero).
module fifo_wr_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             wclk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             s_valid_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             wr_en_o,
  output logic [WIDTH-1:0] wdata_o,
  input  logic             full_i,
  input  logic             error_i,
  input  logic             clr_err_i,
  output logic             err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [15:0]      stall_cnt_o
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned COUNT_W = 2;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mem0;
  logic [WIDTH-1:0]   r_mem1;
  logic [COUNT_W-1:0] r_count;
  logic               r_err;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic               w_run;
  logic               w_push;
  logic               w_pop;

  // State register
  always_ff @(posedge wclk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: error has priority over enable while running
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (en_i && !r_err) w_state_nxt = S_RUN;
      S_RUN: begin
        if (error_i)    w_state_nxt = S_HALT;
        else if (!en_i) w_state_nxt = S_IDLE;
      end
      S_HALT: if (clr_err_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and FIFO write decode; wr_en_o is qualified by full_i directly
  always_comb begin
    w_run     = (r_state == S_RUN);
    busy_o    = (r_count != '0);
    s_ready_o = w_run && (r_count < COUNT_W'(DEPTH));
    wr_en_o   = w_run && busy_o && !full_i && !rst_i;
    wdata_o   = busy_o ? r_mem0 : '0;
    w_push    = s_valid_i && s_ready_o;
    w_pop     = wr_en_o;
    err_o     = r_err;
    wr_cnt_o  = r_wr_cnt;
  end

  // Skid buffer: entry 0 is the head; simultaneous push/pop keeps the count
  always_ff @(posedge wclk_i) begin
    if (rst_i) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) r_mem0 <= s_data_i;
          else               r_mem1 <= s_data_i;
          r_count <= r_count + COUNT_W'(1);
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - COUNT_W'(1);
        end
        2'b11: begin
          if (r_count == COUNT_W'(1)) begin
            r_mem0 <= s_data_i;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= s_data_i;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // Sticky error: a new error wins over a coincident clear
  always_ff @(posedge wclk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (error_i) begin
      r_err <= 1'b1;
    end else if (clr_err_i) begin
      r_err <= 1'b0;
    end
  end

  // Issued-write counter, wraps naturally
  always_ff @(posedge wclk_i) begin
    if (rst_i) begin
      r_wr_cnt <= '0;
    end else if (w_pop) begin
      r_wr_cnt <= r_wr_cnt + CNT_W'(1);
    end
  end

`ifdef FIFO_WR_FEEDER_STALL_CNT_EN
  logic [STALL_W-1:0] r_stall_cnt;

  // Saturating count of cycles with data waiting on a full FIFO
  always_ff @(posedge wclk_i) begin
    if (rst_i || clr_err_i) begin
      r_stall_cnt <= '0;
    end else if (w_run && busy_o && full_i && (r_stall_cnt != {STALL_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// Bench for fifo_wr_feeder: queue-based reference model plus directed scenarios.
module tb_fifo_wr_feeder;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready_o;
  logic        wr_en_o;
  logic [7:0]  wdata_o;
  logic        full = 1'b0;
  logic        err_in = 1'b0;
  logic        clr_err = 1'b0;
  logic        err_o;
  logic        busy_o;
  logic [15:0] wr_cnt_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [7:0]  q[$];
  logic [7:0]  m_log[$];
  int          m_mode = M_IDLE;
  logic        m_err = 1'b0;
  logic [15:0] m_wcnt = 16'h0;
  logic [15:0] m_stall = 16'h0;
  bit          m_acc_last = 1'b0;

  fifo_wr_feeder #(.WIDTH(8), .CNT_W(16)) dut (
    .wclk_i(clk), .rst_i(rst), .en_i(en), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(s_ready_o), .wr_en_o(wr_en_o), .wdata_o(wdata_o), .full_i(full),
    .error_i(err_in), .clr_err_i(clr_err), .err_o(err_o), .busy_o(busy_o),
    .wr_cnt_o(wr_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic f_ready();
    return (m_mode == M_RUN) && (q.size() < 2);
  endfunction

  function automatic logic f_wr();
    return (m_mode == M_RUN) && (q.size() != 0) && !full && !rst;
  endfunction

  function automatic logic [7:0] f_wdata();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  // Model advance on each clock edge
  always @(posedge clk) begin
    logic wr;
    logic acc;
    wr  = f_wr();
    acc = s_valid && f_ready();
    if (rst) begin
      q.delete();
      m_mode = M_IDLE;
      m_err = 1'b0;
      m_wcnt = 16'h0;
      m_stall = 16'h0;
      m_acc_last = 1'b0;
    end else begin
`ifdef FIFO_WR_FEEDER_STALL_CNT_EN
      if (clr_err) m_stall = 16'h0;
      else if (m_mode == M_RUN && q.size() != 0 && full && m_stall != 16'hFFFF) m_stall = m_stall + 16'h1;
`endif
      if (wr) begin
        m_log.push_back(q.pop_front());
        m_wcnt = m_wcnt + 16'h1;
      end
      if (acc) q.push_back(s_data);
      case (m_mode)
        M_IDLE: if (en && !m_err) m_mode = M_RUN;
        M_RUN:  if (err_in) m_mode = M_HALT; else if (!en) m_mode = M_IDLE;
        default: if (clr_err) m_mode = M_IDLE;
      endcase
      if (err_in) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      m_acc_last = acc;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("s_ready", 32'(s_ready_o), 32'(f_ready()));
      check("wr_en", 32'(wr_en_o), 32'(f_wr()));
      check("wdata", 32'(wdata_o), 32'(f_wdata()));
      check("busy", 32'(busy_o), 32'(q.size() != 0));
      check("err", 32'(err_o), 32'(m_err));
      check("wr_cnt", 32'(wr_cnt_o), 32'(m_wcnt));
      check("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input int budget);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (m_acc_last) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic check_log(input string nm, input int n,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({nm, "_len"}, 32'(m_log.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < m_log.size()) check(nm, 32'(m_log[i]), 32'(e[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    chk_on = 1'b1;
    tick(1);
    check("rst_ready", 32'(s_ready_o), 32'd0);
    check("rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
    rst = 1'b0;

    // Back-to-back stream, FIFO not full
    en = 1'b1;
    tick(1);
    send(8'h11, 10); send(8'h22, 10); send(8'h33, 10);
    tick(3);
    check("t1_wr_cnt", 32'(wr_cnt_o), 32'd3);
    check_log("t1_log", 3, 8'h11, 8'h22, 8'h33, 8'h00);
    m_log.delete();

    // Full FIFO backpressure, then release
    full = 1'b1;
    fork
      begin
        send(8'hA0, 40); send(8'hA1, 40); send(8'hA2, 40); send(8'hA3, 40);
      end
      begin
        tick(6);
        check("t2_ready_low", 32'(s_ready_o), 32'd0);
        check("t2_no_write", 32'(wr_en_o), 32'd0);
        check("t2_busy", 32'(busy_o), 32'd1);
        full = 1'b0;
      end
    join
    tick(6);
    check("t2_wr_cnt", 32'(wr_cnt_o), 32'd7);
    check_log("t2_log", 4, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    m_log.delete();

    // Error with one word buffered, then clear and resume
    full = 1'b1;
    send(8'h5C, 10);
    err_in = 1'b1;
    tick(1);
    err_in = 1'b0;
    full = 1'b0;
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_ready", 32'(s_ready_o), 32'd0);
    check("t3_wr_en", 32'(wr_en_o), 32'd0);
    check("t3_busy", 32'(busy_o), 32'd1);
    tick(2);
    check("t3_hold_cnt", 32'(wr_cnt_o), 32'd7);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t3_err_clr", 32'(err_o), 32'd0);
    tick(4);
    check("t3_wr_cnt", 32'(wr_cnt_o), 32'd8);
    check("t3_busy_done", 32'(busy_o), 32'd0);
    check_log("t3_log", 1, 8'h5C, 8'h00, 8'h00, 8'h00);
    m_log.delete();

    // Enable dropped with two words buffered
    full = 1'b1;
    send(8'h61, 10); send(8'h62, 10);
    en = 1'b0;
    tick(1);
    full = 1'b0;
    tick(3);
    check("t4_hold_cnt", 32'(wr_cnt_o), 32'd8);
    check("t4_ready", 32'(s_ready_o), 32'd0);
    check("t4_busy", 32'(busy_o), 32'd1);
    en = 1'b1;
    tick(5);
    check("t4_wr_cnt", 32'(wr_cnt_o), 32'd10);
    check("t4_busy_done", 32'(busy_o), 32'd0);
    check_log("t4_log", 2, 8'h61, 8'h62, 8'h00, 8'h00);
    m_log.delete();

    // Reset with buffer full
    full = 1'b1;
    send(8'h71, 10); send(8'h72, 10);
    rst = 1'b1;
    tick(1);
    check("t5_ready", 32'(s_ready_o), 32'd0);
    check("t5_wr_en", 32'(wr_en_o), 32'd0);
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_wdata", 32'(wdata_o), 32'd0);
    check("t5_err", 32'(err_o), 32'd0);
    check("t5_wr_cnt", 32'(wr_cnt_o), 32'd0);
    check("t5_stall", 32'(stall_cnt_o), 32'd0);
    rst = 1'b0;
    m_log.delete();

    // Full-stall counting with one word waiting
    tick(1);
    send(8'h81, 10);
    tick(5);
`ifdef FIFO_WR_FEEDER_STALL_CNT_EN
    check("t6_stall", 32'(stall_cnt_o), 32'd5);
`else
    check("t6_stall", 32'(stall_cnt_o), 32'd0);
`endif
    full = 1'b0;
    tick(3);
    check("t6_wr_cnt", 32'(wr_cnt_o), 32'd1);
    check_log("t6_log", 1, 8'h81, 8'h00, 8'h00, 8'h00);

    // Coincident error and clear: set wins
    en = 1'b0;
    tick(1);
    err_in = 1'b1;
    clr_err = 1'b1;
    tick(1);
    err_in = 1'b0;
    check("t7_set_wins", 32'(err_o), 32'd1);
    tick(1);
    clr_err = 1'b0;
    check("t7_cleared", 32'(err_o), 32'd0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_feeder.md
Name: fifo_wr_feeder

Overview:
- Write-domain producer stage sitting directly upstream of the async FIFO write port.
- Accepts a valid/ready data stream and buffers it in a 2-entry skid buffer.
- Drives wr_en/wdata into the FIFO and never writes while the FIFO reports full.
- Latches FIFO write errors, halts the stream on error, and keeps a write counter.

Parameters:
- WIDTH, 8, data width; must match the FIFO `WIDTH.
- CNT_W, 16, width of the accepted-write counter.

Ports:
- wclk_i  in  1  write-domain clock.
- rst_i  in  1  reset, synchronous to wclk_i, active-high.
- en_i  in  1  stage enable; low parks the FSM in IDLE.
- s_valid_i  in  1  upstream data valid.
- s_data_i  in  WIDTH  upstream data.
- s_ready_o  out  1  upstream ready.
- wr_en_o  out  1  FIFO write enable.
- wdata_o  out  WIDTH  FIFO write data.
- full_i  in  1  FIFO full flag.
- error_i  in  1  FIFO write-error flag.
- clr_err_i  in  1  single-cycle pulse; clears the sticky error.
- err_o  out  1  sticky error.
- busy_o  out  1  skid buffer non-empty.
- wr_cnt_o  out  CNT_W  number of FIFO writes issued.
- stall_cnt_o  out  16  full-stall cycle count (optional feature).

Behaviour:
- Interface rule: one clock, wclk_i; reset rst_i is synchronous and active-high.
- Reset values: FSM=IDLE, buffer empty, s_ready_o=0, wr_en_o=0, wdata_o=0, err_o=0, busy_o=0, wr_cnt_o=0, stall_cnt_o=0.
- Reset asserted mid-operation discards buffer contents; no write is issued in the reset cycle.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN when en_i=1 and err_o=0.
  - RUN -> IDLE when en_i=0. Buffered entries are kept and drained on return to RUN.
  - RUN -> HALT on error_i=1 (priority over en_i).
  - HALT -> IDLE on clr_err_i=1. Clearing err_o happens in the same edge.
  - IDLE with err_o=1 stays in IDLE.
- Skid buffer: 2 entries, FIFO order, head entry drives wdata_o (0 when empty).
- s_ready_o = (state==RUN) and (count<2). Registered from state and count, so upstream sees no combinational path from full_i.
- Accept: s_valid_i && s_ready_o pushes s_data_i at the edge.
- wr_en_o = (state==RUN) && busy_o && !full_i. Combinational from full_i, so the FIFO never sees a write while full.
- A write pops the head at the edge.
- Push and pop in the same cycle: count unchanged, order preserved; this gives 1 word/cycle sustained.
- Latency: data accepted in cycle N appears on wdata_o/wr_en_o in cycle N+1 at the earliest.
- wr_cnt_o increments on each wr_en_o && !full_i cycle and wraps modulo 2^CNT_W.
- err_o sets on error_i in any state except reset and stays set until clr_err_i.
- clr_err_i coincident with error_i: set wins, err_o stays 1.
- In HALT, wr_en_o=0 and s_ready_o=0. Buffer contents are retained, not flushed.
- full_i held high indefinitely: buffer fills to 2, s_ready_o drops, nothing is lost.
- busy_o = count!=0.

Optional Feature:
- Macro: FIFO_WR_FEEDER_STALL_CNT_EN.
- Defined: stall_cnt_o increments each cycle with state==RUN && busy_o && full_i.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i or clr_err_i.
- Undefined: the port still exists, tied to 0, and no counter logic is built.

Test Plan:
1. Reset, en_i=1, stream 0x11,0x22,0x33 back-to-back, full_i=0 -> wr_en_o high cycles N+1..N+3 with wdata 0x11,0x22,0x33 in order; wr_cnt_o=3.
2. full_i=1 while streaming 4 words -> after 2 accepts s_ready_o=0, wr_en_o stays 0; full_i released -> 0xA0,0xA1 written, then the remaining 2 words; wr_cnt_o=4, no loss or reorder.
3. error_i pulse in RUN with 1 word buffered -> next cycle err_o=1, state HALT, s_ready_o=0, wr_en_o=0; clr_err_i then en_i=1 -> buffered word written.
4. en_i dropped mid-stream with 2 words buffered -> no writes, s_ready_o=0; en_i=1 -> both words written, busy_o falls.
5. rst_i asserted with buffer full -> next cycle all outputs at reset values, no wr_en_o; wr_cnt_o=0.
6. With the macro defined, full_i high 5 cycles with buffer non-empty -> stall_cnt_o=5. Without the macro, stall_cnt_o stays 0.
